// File: rtl/pwm_dispense_sequencer.sv
// Round-robin sharing of one PWM duty channel among N_REQ dispenser motors.
// Ports: clk, rst_n, req, abort in; duty, sel, busy, done, done_id out.
module pwm_dispense_sequencer #(
  parameter int N_REQ       = 4,
  parameter int DUTY_W      = 5,
  parameter int DUTY_MAX    = 24,
  parameter int STEP_CYCLES = 32,
  parameter int HOLD_CYCLES = 256,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic [N_REQ-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [IW-1:0]     done_id
);

  localparam int TMAX =
    (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
  localparam int TW =
    ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] STEP_T = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] ONE = DUTY_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD,
    RAMP_DOWN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [N_REQ-1:0]  sel_q, sel_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic              done_q, done_d;
  logic [IW-1:0]     done_id_q, done_id_d;

  logic              found;
  logic [IW-1:0]     gidx;
  logic [N_REQ-1:0]  gsel;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     rr_next;

  // First set request at or above the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gsel  = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IW'((int'(rr_q) + i) % N_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        gidx      = idx;
        gsel[idx] = 1'b1;
      end
    end
  end

  assign rr_next = (grant_q == IW'(N_REQ - 1)) ?
    '0 : grant_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = RAMP_UP;
          sel_d   = gsel;
          grant_d = gidx;
          duty_d  = '0;
          timer_d = STEP_T;
        end
      end
      RAMP_UP: begin
        // abort freezes duty where it is and starts the ramp down
        if (abort) begin
          state_d = RAMP_DOWN;
          timer_d = STEP_T;
        end else if (timer_q == '0) begin
          timer_d = STEP_T;
          duty_d  = duty_q + ONE;
          if (duty_q + ONE == DMAX) begin
            state_d = HOLD;
            timer_d = HOLD_T;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      HOLD: begin
        if (abort || timer_q == '0) begin
          state_d = RAMP_DOWN;
          timer_d = STEP_T;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RAMP_DOWN: begin
        if (timer_q == '0) begin
          timer_d = STEP_T;
          if (duty_q <= ONE) begin
            duty_d    = '0;
            sel_d     = '0;
            state_d   = DONE;
            done_d    = 1'b1;
            done_id_d = grant_q;
            rr_d      = rr_next;
          end else begin
            duty_d = duty_q - ONE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      sel_q     <= '0;
      timer_q   <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign duty    = duty_q;
  assign sel     = sel_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_pwm_dispense_sequencer.sv
// Bench for pwm_dispense_sequencer: directed scenarios plus random
// traffic compared every cycle against a profile-arithmetic model.
module tb_pwm_dispense_sequencer;

  localparam int N  = 4;
  localparam int DW = 5;
  localparam int DM = 4;
  localparam int S  = 2;
  localparam int H  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] duty;
  logic [N-1:0]  sel;
  logic          busy;
  logic          done;
  logic [1:0]    done_id;

  int total = 0;
  int bad = 0;

  pwm_dispense_sequencer #(
    .N_REQ(N), .DUTY_W(DW), .DUTY_MAX(DM),
    .STEP_CYCLES(S), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
    .duty(duty), .sel(sel), .busy(busy),
    .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a job is described by elapsed cycles since sel rose (m_e),
  // the elapsed cycle where ramp-down starts (m_r) and its start duty.
  bit m_act;
  int m_e, m_r, m_d, m_g, m_rr, m_last;

  function automatic int m_end();
    return m_r + ((m_d > 1) ? m_d : 1) * S;
  endfunction

  function automatic int m_duty();
    if (m_e < m_r)
      return (m_e / S < DM) ? m_e / S : DM;
    return m_d - (m_e - m_r) / S;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_e = 0; m_r = 0; m_d = 0;
      m_g = 0; m_rr = 0; m_last = 0;
    end else if (m_act) begin
      if (m_e == m_end()) begin
        m_act = 0;
        m_rr = (m_g + 1) % N;
        m_last = m_g;
      end else begin
        if (abort && m_e < m_r) begin
          m_d = m_duty();
          m_r = m_e + 1;
        end
        m_e++;
      end
    end else if (req != 0) begin
      bit f;
      f = 0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (!f && req[k]) begin
          f = 1;
          m_g = k;
        end
      end
      m_act = 1; m_e = 0;
      m_r = DM * S + H; m_d = DM;
    end
  end

  logic prev_done = 1'b0;

  always @(posedge clk) begin
    int ed, es, eb, edn, eid;
    #2;
    if (rst_n) begin
      ed = 0; es = 0; eb = 0; edn = 0; eid = m_last;
      if (m_act) begin
        eb = 1;
        if (m_e == m_end()) begin
          edn = 1;
          eid = m_g;
        end else begin
          ed = m_duty();
          es = 1 << m_g;
        end
      end
      chk("duty", duty, ed);
      chk("sel", sel, es);
      chk("busy", busy, eb);
      chk("done", done, edn);
      chk("done_id", done_id, eid);
      chk("duty_le_max", duty <= DM, 1);
      chk("sel_onehot0", $onehot0(sel), 1);
      chk("duty0_when_unsel", (sel == 0) && (duty != 0), 0);
      chk("done_pulse", prev_done && done, 0);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  int prof [20] = '{0,0,1,1,2,2,3,3,4,4,4,4,4,3,3,2,2,1,1,0};
  int ids [5];
  int exp_ids [5] = '{0,1,2,3,0};

  task automatic wait_done(input int lim, output int cnt);
    cnt = 0;
    while (!done && cnt < lim) begin
      @(negedge clk);
      cnt++;
    end
    if (!done) chk("timeout_done", done, 1);
  endtask

  task automatic wait_duty(input int v);
    int c;
    c = 0;
    while (duty != v && c < 60) begin
      @(negedge clk);
      c++;
    end
    if (duty != v) chk("timeout_duty", duty, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c, maxd;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);

    // 1: single one-cycle request, full profile
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    chk("t1_sel", sel, 4'b0100);
    c = 0;
    while (!done && c < 60) begin
      if (c < 20) chk("t1_duty", duty, prof[c]);
      @(negedge clk);
      c++;
    end
    chk("t1_lat", c, 19);
    chk("t1_id", done_id, 2);
    chk("t1_sel_done", sel, 0);

    // 2: all requests held, round-robin order
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(60, c);
      ids[j] = done_id;
      if (j == 0) begin
        @(negedge clk);
        chk("t2_gap_busy", busy, 0);
        @(negedge clk);
        chk("t2_next_sel", sel, 4'b0010);
      end else if (j < 4) begin
        @(negedge clk);
      end
    end
    req = '0;
    for (int j = 0; j < 5; j++) chk("t2_order", ids[j], exp_ids[j]);

    // 3: abort at duty 3 during ramp-up
    @(negedge clk);
    req = 4'b0001;
    wait_duty(3);
    req = '0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_hold_duty", duty, 3);
    maxd = 0;
    wait_done(60, c);
    chk("t3_lat", c, 6);
    chk("t3_id", done_id, 0);

    // 4: abort in first ramp-up cycle, then abort while idle
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    chk("t4_sel", sel, 4'b0010);
    abort = 1'b1;
    req = '0;
    @(negedge clk);
    abort = 1'b0;
    c = 0;
    while (!done && c < 60) begin
      if (duty > maxd) maxd = duty;
      @(negedge clk);
      c++;
    end
    chk("t4_lat", c, 2);
    chk("t4_maxduty", maxd, 0);
    abort = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("t4_idle_busy", busy, 0);
    end
    abort = 1'b0;

    // 5: reset during hold
    req = 4'b0100;
    wait_duty(4);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_duty", duty, 0);
    chk("t5_sel", sel, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_grant3", sel, 4'b1000);
    req = '0;
    wait_done(60, c);
    chk("t5_id", done_id, 3);

    // 6: granted request dropped mid ramp-up
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    repeat (2) @(negedge clk);
    req = '0;
    c = 2;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("t6_lat", c, 19);
    chk("t6_id", done_id, 0);

    // random traffic
    for (int j = 0; j < 1500; j++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      abort = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    req = '0;
    abort = 1'b0;
    repeat (40) @(negedge clk);
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
